// File: rtl/delay_meas.sv
// Measures loop-back delay of a calibration pulse: after a trig rising edge, scans
// incoming sample words for the first lane above threshold and reports {cycle, lane}.
module delay_meas #(
  parameter int unsigned NUM_LANES = 16,
  parameter int unsigned SAMPLE_W  = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            trig,
  input  logic [NUM_LANES*SAMPLE_W-1:0]   adc_word,
  input  logic signed [SAMPLE_W-1:0]      threshold,
  input  logic [CNT_W-1:0]                timeout,
  output logic [CNT_W+3:0]                delay_out,
  output logic                            valid,
  output logic                            timed_out,
  output logic                            busy
);

  localparam int unsigned LANE_W = 4;
  localparam int unsigned OUT_W  = CNT_W + LANE_W;

  typedef enum logic [1:0] {IDLE, MEAS, DONE} state_t;

  state_t                     state, state_d;
  logic                       trig_q;
  logic [CNT_W-1:0]           cnt, cnt_d;
  logic [OUT_W-1:0]           delay_d;
  logic                       valid_d, timed_out_d;
  logic signed [SAMPLE_W-1:0] thr_q, thr_d;
  logic [CNT_W-1:0]           to_q, to_d;
  logic                       rise;
  logic                       hit;
  logic [LANE_W-1:0]          hit_lane;

  assign rise = trig & ~trig_q;

  // Lowest-index lane strictly above the captured threshold wins.
  always_comb begin
    hit      = 1'b0;
    hit_lane = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      if ($signed(adc_word[k*SAMPLE_W +: SAMPLE_W]) > thr_q) begin
        hit      = 1'b1;
        hit_lane = LANE_W'(k);
      end
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    delay_d     = delay_out;
    valid_d     = valid;
    timed_out_d = timed_out;
    thr_d       = thr_q;
    to_d        = to_q;
    case (state)
      IDLE, DONE: begin
        if (rise) begin
          state_d     = MEAS;
          thr_d       = threshold;
          to_d        = timeout;
          cnt_d       = '0;
          valid_d     = 1'b0;
          timed_out_d = 1'b0;
        end
      end
      MEAS: begin
        // A hit on the last permitted word still counts as a detection.
        if (hit) begin
          delay_d = {cnt, hit_lane};
          valid_d = 1'b1;
          state_d = DONE;
        end else if (cnt == to_q) begin
          delay_d     = '1;
          timed_out_d = 1'b1;
          valid_d     = 1'b0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      trig_q    <= 1'b0;
      cnt       <= '0;
      delay_out <= '0;
      valid     <= 1'b0;
      timed_out <= 1'b0;
      busy      <= 1'b0;
      thr_q     <= '0;
      to_q      <= '0;
    end else begin
      state     <= state_d;
      trig_q    <= trig;
      cnt       <= cnt_d;
      delay_out <= delay_d;
      valid     <= valid_d;
      timed_out <= timed_out_d;
      busy      <= (state_d == MEAS);
      thr_q     <= thr_d;
      to_q      <= to_d;
    end
  end

endmodule

// File: tb/tb_delay_meas.sv
// Scoreboard bench for delay_meas: a driver pushes reference-model results, a monitor
// pops them whenever busy falls and compares the reported outcome.
module tb_delay_meas;

  localparam int unsigned NL = 16;
  localparam int unsigned SW = 16;
  localparam int unsigned CW = 16;
  localparam int unsigned OW = CW + 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 trig = 1'b0;
  logic [NL*SW-1:0]     adc_word = '0;
  logic signed [SW-1:0] threshold = '0;
  logic [CW-1:0]        timeout = '0;
  logic [OW-1:0]        delay_out;
  logic                 valid;
  logic                 timed_out;
  logic                 busy;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic          v;
    logic          t;
    logic [OW-1:0] d;
  } exp_t;

  exp_t         expq[$];
  logic [255:0] wq[$];
  exp_t         mon_e;
  logic         busy_prev = 1'b0;

  delay_meas #(.NUM_LANES(NL), .SAMPLE_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .trig(trig), .adc_word(adc_word),
    .threshold(threshold), .timeout(timeout),
    .delay_out(delay_out), .valid(valid), .timed_out(timed_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] fill(input int v);
    logic [255:0] w;
    for (int k = 0; k < int'(NL); k++) w[k*SW +: SW] = 16'(v);
    return w;
  endfunction

  // Reference: scan words 0..timeout, first sample above threshold in time order.
  function automatic exp_t model(input logic signed [SW-1:0] thr, input logic [CW-1:0] to);
    exp_t e;
    logic [255:0] w;
    logic signed [SW-1:0] s;
    for (int c = 0; c <= int'(to); c++) begin
      w = (c < wq.size()) ? wq[c] : '0;
      for (int k = 0; k < int'(NL); k++) begin
        s = w[k*SW +: SW];
        if (s > thr) begin
          e.v = 1'b1;
          e.t = 1'b0;
          e.d = {16'(c), 4'(k)};
          return e;
        end
      end
    end
    e.v = 1'b0;
    e.t = 1'b1;
    e.d = '1;
    return e;
  endfunction

  task automatic run_meas(input logic signed [SW-1:0] thr, input logic [CW-1:0] to, input bit pulse);
    exp_t e;
    e = model(thr, to);
    expq.push_back(e);
    threshold = thr;
    timeout   = to;
    trig      = 1'b1;
    @(posedge clk); #1;
    check("arm_busy", 32'(busy), 32'd1);
    check("arm_valid_clr", 32'(valid), 32'd0);
    check("arm_tmo_clr", 32'(timed_out), 32'd0);
    threshold = 16'($urandom);
    timeout   = 16'($urandom);
    for (int i = 0; i <= int'(to) + 2; i++) begin
      adc_word = (i < wq.size()) ? wq[i] : '0;
      if (pulse && i == 1) trig = 1'b0;
      if (pulse && i == 2) trig = 1'b1;
      @(posedge clk); #1;
      if (!busy) break;
    end
    check("meas_ends", 32'(busy), 32'd0);
    adc_word = fill(32000);
    repeat (3) @(posedge clk);
    #1;
    check("hold_busy", 32'(busy), 32'd0);
    check("hold_valid", 32'(valid), 32'(e.v));
    check("hold_tmo", 32'(timed_out), 32'(e.t));
    check("hold_delay", 32'(delay_out), 32'(e.d));
    trig = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      busy_prev = 1'b0;
    end else begin
      if (busy_prev && !busy) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=result required=none");
        end else begin
          mon_e = expq.pop_front();
          check("res_valid", 32'(valid), 32'(mon_e.v));
          check("res_tmo", 32'(timed_out), 32'(mon_e.t));
          check("res_delay", 32'(delay_out), 32'(mon_e.d));
        end
      end
      busy_prev = busy;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] w;
    int thr, to, h, v, fl;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_delay", 32'(delay_out), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_tmo", 32'(timed_out), 32'd0);

    // Five quiet words, then lane 7 crosses.
    wq.delete();
    for (int c = 0; c < 5; c++) wq.push_back(fill(0));
    w = fill(0); w[7*SW +: SW] = 16'(1200); wq.push_back(w);
    run_meas(16'(1000), 16'(100), 1'b0);
    // Same scenario with a second trig pulse during the measurement.
    run_meas(16'(1000), 16'(100), 1'b1);

    wq.delete();
    w = fill(0); w[3*SW +: SW] = 16'(2000); w[9*SW +: SW] = 16'(2000); wq.push_back(w);
    run_meas(16'(1000), 16'(100), 1'b0);

    wq.delete();
    for (int c = 0; c < 3; c++) wq.push_back(fill(1000));
    run_meas(16'(1000), 16'(2), 1'b0);

    wq.delete();
    wq.push_back(fill(-5));
    run_meas(-16'sd10, 16'(10), 1'b0);

    wq.delete();
    for (int c = 0; c < 12; c++) wq.push_back(fill(0));
    run_meas(16'(100), 16'(10), 1'b0);

    wq.delete();
    for (int c = 0; c < 4; c++) wq.push_back(fill(-50));
    w = fill(-50); w[15*SW +: SW] = 16'(51); wq.push_back(w);
    run_meas(16'(50), 16'(4), 1'b0);

    wq.delete();
    wq.push_back(fill(7)); wq.push_back(fill(500));
    run_meas(16'(7), 16'(0), 1'b0);
    wq.delete();
    w = fill(0); w[12*SW +: SW] = 16'(8); wq.push_back(w);
    run_meas(16'(7), 16'(0), 1'b0);

    // Reset during measurement cycle 3 aborts without a result.
    wq.delete();
    threshold = 16'(100);
    timeout   = 16'(50);
    adc_word  = fill(0);
    trig      = 1'b1;
    @(posedge clk); #1;
    check("abort_arm_busy", 32'(busy), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_tmo", 32'(timed_out), 32'd0);
    check("abort_delay", 32'(delay_out), 32'd0);
    trig = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_abort_idle", 32'(busy), 32'd0);
    for (int c = 0; c < 2; c++) wq.push_back(fill(0));
    w = fill(0); w[0] = 1'b1; w[5*SW +: SW] = 16'(300); wq.push_back(w);
    run_meas(16'(0), 16'(20), 1'b0);

    // Randomised measurements: quiet words, a crossing word, then noise.
    for (int r = 0; r < 40; r++) begin
      thr = int'($urandom_range(0, 4000)) - 2000;
      to  = int'($urandom_range(0, 12));
      h   = int'($urandom_range(0, to + 2));
      wq.delete();
      for (int c = 0; c <= to; c++) begin
        w = '0;
        for (int k = 0; k < int'(NL); k++) begin
          if (c < h) begin
            v = ($urandom_range(0, 7) == 0) ? thr : thr - int'($urandom_range(0, 300));
          end else if (c == h) begin
            v = ($urandom_range(0, 3) == 0) ? thr + 1 + int'($urandom_range(0, 300))
                                             : thr - int'($urandom_range(0, 300));
          end else begin
            v = int'($urandom_range(0, 6000)) - 3000;
          end
          w[k*SW +: SW] = 16'(v);
        end
        if (c == h) begin
          fl = int'($urandom_range(0, NL - 1));
          w[fl*SW +: SW] = 16'(thr + 1);
        end
        wq.push_back(w);
      end
      run_meas(16'(thr), 16'(to), bit'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drain", 32'(expq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
